// File: rtl/branch_cmp_pkg.sv
// rtl/branch_cmp_pkg.sv - mode encodings, FSM state constants and branch decode helpers
package branch_cmp_pkg;

    localparam logic [2:0] MODE_BEQ  = 3'b000;
    localparam logic [2:0] MODE_BNE  = 3'b001;
    localparam logic [2:0] MODE_BLT  = 3'b100;
    localparam logic [2:0] MODE_BGE  = 3'b101;
    localparam logic [2:0] MODE_BLTU = 3'b110;
    localparam logic [2:0] MODE_BGEU = 3'b111;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    function automatic logic mode_illegal(input logic [2:0] m);
        return m[2:1] == 2'b01;
    endfunction

    function automatic logic mode_signed(input logic [2:0] m);
        return m[2:1] == 2'b10;
    endfunction

    function automatic logic branch_taken(input logic [2:0] m, input logic eq, input logic lt);
        logic t;
        case (m)
            MODE_BEQ:             t = eq;
            MODE_BNE:             t = !eq;
            MODE_BLT, MODE_BLTU:  t = lt;
            MODE_BGE, MODE_BGEU:  t = !lt;
            default:              t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/branch_cmp_iter_chunk_cmp.sv
// rtl/branch_cmp_iter_chunk_cmp.sv - combinational CHUNK-bit compare; signed by flipping both MSBs
module chunk_cmp #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             signed_i,
    output logic             eq_o,
    output logic             lt_o
);

    logic [CHUNK-1:0] flip;

    always_comb begin
        flip            = '0;
        flip[CHUNK-1]   = signed_i;
    end

    assign eq_o = (a_i == b_i);
    assign lt_o = ((a_i ^ flip) < (b_i ^ flip));

endmodule

// File: rtl/branch_cmp_iter.sv
// rtl/branch_cmp_iter.sv - iterative MSB-first branch comparator; BRANCH_CMP_EARLY_EXIT_EN stops at first differing chunk
module branch_cmp_iter
    import branch_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1d,
    input  logic [WIDTH-1:0] rs2d,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic             lt,
    output logic             taken,
    output logic             bad_mode
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

    state_t            state_q;
    logic [IDXW-1:0]   idx_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [2:0]        mode_q;
    logic              eq_q, lt_q, taken_q, bad_q;

    logic              c_eq, c_lt;
    logic              eq_d, lt_d, last_d;

    // Operands shift left each RUN cycle, so the chunk under test is always the top one.
    chunk_cmp #(.CHUNK(CHUNK)) u_chunk (
        .a_i      (a_q[WIDTH-1 -: CHUNK]),
        .b_i      (b_q[WIDTH-1 -: CHUNK]),
        .signed_i (mode_signed(mode_q) && (idx_q == IDX_TOP)),
        .eq_o     (c_eq),
        .lt_o     (c_lt)
    );

    // eq_q stays 1 until the first difference, which is the only point lt may be set.
    always_comb begin
        eq_d   = eq_q & c_eq;
        lt_d   = (eq_q && !c_eq) ? c_lt : lt_q;
`ifdef BRANCH_CMP_EARLY_EXIT_EN
        last_d = (idx_q == '0) || !c_eq;
`else
        last_d = (idx_q == '0);
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_BEQ;
            eq_q    <= 1'b0;
            lt_q    <= 1'b0;
            taken_q <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= rs1d;
                        b_q     <= rs2d;
                        mode_q  <= mode;
                        idx_q   <= IDX_TOP;
                        eq_q    <= 1'b1;
                        lt_q    <= 1'b0;
                        taken_q <= 1'b0;
                        bad_q   <= mode_illegal(mode);
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    eq_q  <= eq_d;
                    lt_q  <= lt_d;
                    a_q   <= a_q << CHUNK;
                    b_q   <= b_q << CHUNK;
                    idx_q <= idx_q - IDXW'(1);
                    if (last_d) begin
                        taken_q <= branch_taken(mode_q, eq_d, lt_d);
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign eq        = eq_q;
    assign lt        = lt_q;
    assign taken     = taken_q;
    assign bad_mode  = bad_q;

endmodule

// File: doc/branch_cmp_iter.md
BRANCH_CMP_ITER -- requirements
Module: branch_cmp_iter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; WIDTH % CHUNK == 0 required; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port rs1d  input  WIDTH  operand 1.
REQ-008 SHALL have port rs2d  input  WIDTH  operand 2.
REQ-009 SHALL have port mode  input  3  funct3: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes result.
REQ-012 SHALL have port eq  output  1  rs1d == rs2d.
REQ-013 SHALL have port lt  output  1  rs1d < rs2d (signed for 100/101, else unsigned).
REQ-014 SHALL have port taken  output  1  branch outcome for mode.
REQ-015 SHALL have port bad_mode  output  1  mode was 010 or 011.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 SHALL accept on in_valid && in_ready: latch rs1d, rs2d, mode; chunk index := NCHUNK-1; go RUN.
REQ-018 SHALL, each RUN cycle, compare chunk index MSB-first; for signed modes the top chunk SHALL be compared with both MSBs inverted, lower chunks unsigned.
REQ-019 SHALL record lt from the first (most significant) differing chunk; later chunks SHALL NOT modify it.
REQ-020 SHALL leave RUN for DONE after the chunk at index 0 is processed (or earlier per REQ-030).
REQ-021 SHALL hold eq, lt, taken, bad_mode stable in DONE until out_ready; out_valid && out_ready returns to IDLE.
REQ-022 SHALL compute taken: BEQ eq, BNE !eq, BLT/BLTU lt, BGE/BGEU !lt.
REQ-023 SHALL, for illegal mode, set bad_mode = 1, taken = 0, eq/lt computed unsigned.
REQ-024 SHALL ignore rs1d/rs2d/mode/in_valid changes outside IDLE.
REQ-025 SHALL with WIDTH == CHUNK complete in a single RUN cycle.
REQ-026 SHALL give equal operands eq = 1, lt = 0 after all NCHUNK chunks.

Reset
REQ-027 SHALL on reset (any time, incl. mid-RUN or DONE) go IDLE, abandon operation: in_ready = 1, out_valid = 0, eq = lt = taken = bad_mode = 0.
REQ-028 SHALL accept first request in first cycle after reset deassertion.

Configuration
REQ-029 SHALL support macro BRANCH_CMP_EARLY_EXIT_EN.
REQ-030 SHALL with macro defined, go DONE on the first differing chunk; out_valid rises k cycles after acceptance edge, k = chunks examined (1..NCHUNK).
REQ-031 SHALL without macro, always take NCHUNK RUN cycles; out_valid rises exactly NCHUNK cycles after acceptance edge.

Structure
REQ-032 SHALL place mode encodings (localparams) and FSM state typedef in package branch_cmp_pkg.
REQ-033 SHALL use one combinational sub-module chunk_cmp (CHUNK-bit a, b, signed flag -> eq, lt).

Verification (WIDTH=32, CHUNK=8)
REQ-034 SHALL test BLT 0xFFFFFFFF vs 0x00000001 -> lt=1, eq=0, taken=1; early-exit build out_valid 1 cycle after accept, else 4.
REQ-035 SHALL test BLTU same operands -> lt=0, eq=0, taken=0.
REQ-036 SHALL test BEQ 0x12345678 vs 0x12345678 -> eq=1, lt=0, taken=1, out_valid 4 cycles after accept in both builds.
REQ-037 SHALL test BGE 0x12345600 vs 0x12345601 -> lt=1, taken=0, 4 cycles (difference in chunk 0).
REQ-038 SHALL test out_ready low 5 cycles in DONE -> outputs stable, in_ready=0; then reset mid-RUN -> out_valid=0, in_ready=1 immediately.
REQ-039 SHALL test mode 3'b010 with 0x5 vs 0x5 -> bad_mode=1, taken=0, eq=1.
